// File: rtl/coin_pkg.sv
// Shared types and sizing helpers for the coin-slot front end.
package coin_pkg;

  typedef enum logic [1:0] {
    Idle      = 2'd0,
    Arming    = 2'd1,
    Held      = 2'd2,
    Releasing = 2'd3
  } CoinDebState;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int JAM_CYCLES_DEF      = 64;

  // The counter must be able to hold JAM_CYCLES, which always exceeds DEBOUNCE_CYCLES.
  function automatic int cnt_width(input int jam_cycles);
    return $clog2(jam_cycles + 1);
  endfunction

  localparam int CNT_W = $clog2(JAM_CYCLES_DEF + 1);

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, debounce FSM with press/release
// filtering, a one-cycle accept event and a stuck-high indication.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt,
  output logic stuck
);

  localparam int              CW       = cnt_width(JAM_CYCLES);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   JAM_MAX  = CW'(JAM_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          r_meta;
  logic          r_sync;
  CoinDebState   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_evt;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= raw;
      r_sync <= r_meta;
    end
  end

  // Counter compares against DEBOUNCE_CYCLES-1 so the accept lands on the
  // DEBOUNCE_CYCLES-th stable synchronised cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= Idle;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      case (r_state)
        Idle: begin
          if (r_sync) begin
            r_state <= Arming;
            r_cnt   <= CNT_ONE;
          end
        end
        Arming: begin
          if (!r_sync) begin
            r_state <= Idle;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= Held;
            r_cnt   <= '0;
            r_evt   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        Held: begin
          if (!r_sync) begin
            r_state <= Releasing;
            r_cnt   <= CNT_ONE;
          end else if (r_cnt != JAM_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        Releasing: begin
          // A bounce back high returns to Held without a second accept.
          if (r_sync) begin
            r_state <= Held;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= Idle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= Idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign evt   = r_evt;
  assign stuck = (r_state == Held) && (r_cnt == JAM_MAX);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced channels, dime-first arbitration with a
// one-deep nickel deferral, inhibit steering to reject, and a sticky jam latch.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int JAM_CYCLES      = JAM_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic nickel_raw,
  input  logic dime_raw,
  input  logic inhibit,
  output logic nickel,
  output logic dime,
  output logic reject,
  output logic jam
);

  logic w_evt_n;
  logic w_evt_d;
  logic w_stuck_n;
  logic w_stuck_d;
  logic w_issue_n;
  logic w_issue_d;
  logic w_issue_any;

  logic r_pend;
  logic r_jam;

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_nickel_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (nickel_raw),
    .evt   (w_evt_n),
    .stuck (w_stuck_n)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_dime_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (dime_raw),
    .evt   (w_evt_d),
    .stuck (w_stuck_d)
  );

  // A deferred nickel wins its cycle; event spacing guarantees no channel
  // fires again that soon, so nothing is lost behind it.
  assign w_issue_n   = r_pend | (w_evt_n & ~w_evt_d);
  assign w_issue_d   = w_evt_d & ~r_pend;
  assign w_issue_any = (w_issue_n | w_issue_d) & ~r_jam;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_jam  <= 1'b0;
    end else begin
      r_pend <= w_evt_n & (w_evt_d | r_pend);
      r_jam  <= r_jam | w_stuck_n | w_stuck_d;
    end
  end

  // Inhibit is applied in the issue cycle itself, including for a deferred nickel.
  assign nickel = w_issue_n & ~w_issue_d & ~inhibit & ~r_jam;
  assign dime   = w_issue_d & ~inhibit & ~r_jam;
  assign reject = w_issue_any & inhibit;
  assign jam    = r_jam;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues the expected pulse and its
// cycle; a negedge monitor pops and compares whenever a pulse is due or seen.
module tb_coin_acceptor;

  localparam int K_NONE   = 0;
  localparam int K_NICKEL = 1;
  localparam int K_DIME   = 2;
  localparam int K_REJECT = 3;
  localparam int K_MULTI  = 4;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic nickel_raw;
  logic dime_raw;
  logic inhibit;
  logic nickel;
  logic dime;
  logic reject;
  logic jam;

  int   cyc  = 0;
  int   vec  = 0;
  int   errs = 0;
  exp_t q[$];

  coin_acceptor #(
    .DEBOUNCE_CYCLES (4),
    .JAM_CYCLES      (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .nickel_raw (nickel_raw),
    .dime_raw   (dime_raw),
    .inhibit    (inhibit),
    .nickel     (nickel),
    .dime       (dime),
    .reject     (reject),
    .jam        (jam)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_out(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the selected raw lines at the current negedge for len cycles.
  task automatic drive(input logic n, input logic d, input int len);
    nickel_raw = n;
    dime_raw   = d;
    repeat (len) @(negedge clk);
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
  endtask

  always @(negedge clk) begin
    int   act;
    int   nsum;
    exp_t e;
    nsum = int'(nickel) + int'(dime) + int'(reject);
    if (nsum > 1)    act = K_MULTI;
    else if (nickel) act = K_NICKEL;
    else if (dime)   act = K_DIME;
    else if (reject) act = K_REJECT;
    else             act = K_NONE;
    if (q.size() > 0 && q[0].at == cyc) begin
      e = q.pop_front();
      check("output_kind", act, e.kind);
    end else if (act != K_NONE) begin
      check("unexpected_output", act, K_NONE);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n0;
    rst        = 1'b1;
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    inhibit    = 1'b0;
    idle(3);
    check("reset_jam", jam, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_nickel", nickel, 0);
    check("post_reset_dime", dime, 0);
    check("post_reset_reject", reject, 0);
    check("post_reset_jam", jam, 0);

    // Clean nickel: raw up at edge 0, pulse in the cycle after edge 5.
    expect_out(K_NICKEL, cyc + 6);
    drive(1'b1, 1'b0, 10);
    idle(20);
    check("clean_no_jam", jam, 0);

    // Short glitches below the debounce threshold.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, k);
      idle(10);
    end

    // Exactly DEBOUNCE_CYCLES of high is enough.
    expect_out(K_NICKEL, cyc + 6);
    drive(1'b1, 1'b0, 4);
    idle(20);

    // Release bounce: one pulse only.
    expect_out(K_NICKEL, cyc + 6);
    nickel_raw = 1'b1;
    idle(8);
    nickel_raw = 1'b0;
    idle(2);
    nickel_raw = 1'b1;
    idle(2);
    nickel_raw = 1'b0;
    idle(20);

    // Simultaneous coins: dime first, nickel the next cycle.
    expect_out(K_DIME, cyc + 6);
    expect_out(K_NICKEL, cyc + 7);
    drive(1'b1, 1'b1, 10);
    idle(20);

    // Inhibited dime becomes reject.
    inhibit = 1'b1;
    expect_out(K_REJECT, cyc + 6);
    drive(1'b0, 1'b1, 10);
    inhibit = 1'b0;
    idle(20);

    // Simultaneous coins with inhibit dropping between the two issue cycles.
    n0 = cyc;
    inhibit = 1'b1;
    expect_out(K_REJECT, n0 + 6);
    expect_out(K_NICKEL, n0 + 7);
    nickel_raw = 1'b1;
    dime_raw   = 1'b1;
    wait_cyc(n0 + 6);
    @(posedge clk);
    #1 inhibit = 1'b0;
    wait_cyc(n0 + 10);
    nickel_raw = 1'b0;
    dime_raw   = 1'b0;
    idle(20);

    // Jam: dime held 70 cycles; Held counter hits 64 in the cycle after edge n0+70.
    n0 = cyc;
    expect_out(K_DIME, n0 + 6);
    dime_raw = 1'b1;
    wait_cyc(n0 + 70);
    check("jam_before_limit", jam, 0);
    dime_raw = 1'b0;
    wait_cyc(n0 + 71);
    check("jam_at_limit", jam, 1);
    idle(20);

    // Nickel while jammed produces nothing.
    drive(1'b1, 1'b0, 10);
    idle(20);
    check("jam_sticky", jam, 1);

    rst = 1'b1;
    idle(2);
    check("jam_cleared_by_reset", jam, 0);
    rst = 1'b0;
    idle(2);
    expect_out(K_NICKEL, cyc + 6);
    drive(1'b1, 1'b0, 10);
    idle(20);
    check("jam_stays_clear", jam, 0);

    // Reset during Arming with raw held: coin restarts from reset release.
    n0 = cyc;
    nickel_raw = 1'b1;
    wait_cyc(n0 + 3);
    rst = 1'b1;
    wait_cyc(n0 + 5);
    rst = 1'b0;
    expect_out(K_NICKEL, cyc + 6);
    wait_cyc(n0 + 15);
    nickel_raw = 1'b0;
    idle(20);

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
